// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared state encoding and frame constants for the program loader
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        A_HI  = 3'd1,
        A_LO  = 3'd2,
        C_HI  = 3'd3,
        C_LO  = 3'd4,
        D_HI  = 3'd5,
        D_LO  = 3'd6,
        CHECK = 3'd7
    } state_t;

    localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

endpackage

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-stream framed loader writing 16-bit words into program memory
module prog_loader
    import loader_pkg::*;
#(
    parameter int         N_ELEMENTS = 128,
    parameter int         ADDR_WIDTH = 16,
    parameter int         DATA_WIDTH = 16,
    parameter logic [7:0] MAGIC      = MAGIC_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            in_byte,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [DATA_WIDTH-1:0] w_data,
    output logic                  w_en,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  err
);

    state_t      state, state_next;
    logic [15:0] cur_addr;
    logic [15:0] remaining;
    logic [7:0]  hi_byte;
    logic [7:0]  csum;
    logic        xfer;
    logic [15:0] cnt_full;
    logic [16:0] end_addr;
    logic        over_range;

    assign in_ready   = 1'b1;
    assign xfer       = in_valid & in_ready;
    // CNT_HI is parked in remaining[15:8] until CNT_LO completes the count
    assign cnt_full   = {remaining[15:8], in_byte};
    assign end_addr   = {1'b0, cur_addr} + {1'b0, cnt_full};
    assign over_range = end_addr > 17'(N_ELEMENTS);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (xfer) begin
            unique case (state)
                IDLE:    if (in_byte == MAGIC) state_next = A_HI;
                A_HI:    state_next = A_LO;
                A_LO:    state_next = C_HI;
                C_HI:    state_next = C_LO;
                C_LO:    begin
                    if (over_range)           state_next = IDLE;
                    else if (cnt_full == '0)  state_next = CHECK;
                    else                      state_next = D_HI;
                end
                D_HI:    state_next = D_LO;
                D_LO:    state_next = (remaining == 16'd1) ? CHECK : D_HI;
                CHECK:   state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_addr  <= '0;
            remaining <= '0;
            hi_byte   <= '0;
            csum      <= '0;
            w_en      <= 1'b0;
            w_addr    <= '0;
            w_data    <= '0;
            cpu_hold  <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            w_en <= 1'b0;
            if (xfer) begin
                unique case (state)
                    IDLE: begin
                        if (in_byte == MAGIC) begin
                            cpu_hold <= 1'b1;
                            done     <= 1'b0;
                            err      <= 1'b0;
                            csum     <= '0;
                        end
                    end
                    A_HI: begin
                        cur_addr <= {in_byte, 8'h00};
                        csum     <= csum ^ in_byte;
                    end
                    A_LO: begin
                        cur_addr[7:0] <= in_byte;
                        csum          <= csum ^ in_byte;
                    end
                    C_HI: begin
                        remaining <= {in_byte, 8'h00};
                        csum      <= csum ^ in_byte;
                    end
                    C_LO: begin
                        remaining <= cnt_full;
                        csum      <= csum ^ in_byte;
                        if (over_range) begin
                            err      <= 1'b1;
                            cpu_hold <= 1'b0;
                        end
                    end
                    D_HI: begin
                        hi_byte <= in_byte;
                        csum    <= csum ^ in_byte;
                    end
                    D_LO: begin
                        w_en      <= 1'b1;
                        w_addr    <= cur_addr[ADDR_WIDTH-1:0];
                        w_data    <= {hi_byte, in_byte};
                        cur_addr  <= cur_addr + 16'd1;
                        remaining <= remaining - 16'd1;
                        csum      <= csum ^ in_byte;
                    end
                    CHECK: begin
                        if (csum == in_byte) done <= 1'b1;
                        else                 err  <= 1'b1;
                        cpu_hold <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed self-checking bench for prog_loader
module tb_prog_loader;

    typedef logic [7:0] byte_q_t [$];

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] w_addr;
    logic [15:0] w_data;
    logic        w_en;
    logic        cpu_hold;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;
    logic [31:0] wr_q [$];

    prog_loader dut (
        .clk      (clk),
        .rst      (rst),
        .in_byte  (in_byte),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .w_addr   (w_addr),
        .w_data   (w_data),
        .w_en     (w_en),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (w_en) wr_q.push_back({w_addr, w_data});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] frame_csum(input byte_q_t f);
        logic [7:0] c = 8'h00;
        for (int i = 1; i < f.size(); i++) c ^= f[i];
        return c;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_byte  = b;
        in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input byte_q_t f, input int gap_max);
        foreach (f[i]) begin
            send_byte(f[i]);
            if (gap_max > 0) tick($urandom_range(gap_max, 0));
        end
    endtask

    task automatic check_frame1_writes(input string tag);
        check({tag, "_nwr"}, wr_q.size(), 2);
        if (wr_q.size() == 2) begin
            check({tag, "_wr0"}, wr_q[0], {16'h0010, 16'h1234});
            check({tag, "_wr1"}, wr_q[1], {16'h0011, 16'hABCD});
        end
    endtask

    byte_q_t f1;
    byte_q_t fb;

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        in_byte  = 8'h00;
        tick(3);
        check("rst_in_ready", in_ready, 1);
        check("rst_w_en", w_en, 0);
        check("rst_w_addr", w_addr, 0);
        check("rst_w_data", w_data, 0);
        check("rst_cpu_hold", cpu_hold, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        rst = 1'b1;
        tick(2);

        // Frame 1: two words at 0x10; XOR of bytes after MAGIC is 0x52
        f1 = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        check("f1_csum_model", frame_csum(f1), 8'h52);
        f1.push_back(frame_csum(f1));

        wr_q.delete();
        for (int i = 0; i < 9; i++) send_byte(f1[i]);
        check("t1_hold_mid", cpu_hold, 1);
        send_byte(f1[9]);
        check_frame1_writes("t1");
        check("t1_done", done, 1);
        check("t1_err", err, 0);
        check("t1_hold", cpu_hold, 0);
        check("t1_w_hold_addr", w_addr, 16'h0011);
        check("t1_w_hold_data", w_data, 16'hABCD);

        // Bad checksum: words still land, err raised
        wr_q.delete();
        fb = f1;
        fb[9] = 8'h00;
        send_frame(fb, 0);
        check_frame1_writes("t2");
        check("t2_err", err, 1);
        check("t2_done", done, 0);
        check("t2_hold", cpu_hold, 0);

        // Range overflow: 0x7F + 2 = 129 > 128
        wr_q.delete();
        fb = '{8'hA5, 8'h00, 8'h7F, 8'h00, 8'h02};
        send_frame(fb, 0);
        check("t3_err", err, 1);
        check("t3_done", done, 0);
        check("t3_hold", cpu_hold, 0);
        fb = '{8'h12, 8'h34, 8'hAB, 8'hCD};
        send_frame(fb, 0);
        tick(2);
        check("t3_nwr", wr_q.size(), 0);
        check("t3_err_level", err, 1);

        // Exact fit: 0x7E + 2 = 128 is allowed
        wr_q.delete();
        fb = '{8'hA5, 8'h00, 8'h7E, 8'h00, 8'h02, 8'h00, 8'h01, 8'h00, 8'h02};
        fb.push_back(frame_csum(fb));
        send_frame(fb, 0);
        check("t3b_nwr", wr_q.size(), 2);
        if (wr_q.size() == 2) check("t3b_wr1", wr_q[1], {16'h007F, 16'h0002});
        check("t3b_done", done, 1);

        // Zero-count frame
        wr_q.delete();
        fb = '{8'hA5, 8'h00, 8'h05, 8'h00, 8'h00, 8'h05};
        send_frame(fb, 0);
        tick(2);
        check("t4_nwr", wr_q.size(), 0);
        check("t4_done", done, 1);
        check("t4_err", err, 0);

        // Junk in IDLE is dropped and leaves status levels untouched
        wr_q.delete();
        fb = '{8'h00, 8'hFF, 8'h12};
        send_frame(fb, 0);
        check("t5_hold", cpu_hold, 0);
        check("t5_done_level", done, 1);
        send_frame(f1, 0);
        check_frame1_writes("t5");
        check("t5_done", done, 1);

        // Async reset mid-frame
        wr_q.delete();
        for (int i = 0; i < 6; i++) send_byte(f1[i]);
        check("t6_hold_pre", cpu_hold, 1);
        #2 rst = 1'b0;
        #1;
        check("t6_hold", cpu_hold, 0);
        check("t6_done", done, 0);
        check("t6_w_en", w_en, 0);
        check("t6_w_addr", w_addr, 0);
        tick(1);
        rst = 1'b1;
        tick(2);
        check("t6_nwr", wr_q.size(), 0);
        send_frame(f1, 0);
        check_frame1_writes("t6");
        check("t6_done_after", done, 1);

        // Gapped valid over frame 1
        wr_q.delete();
        send_frame(f1, 3);
        tick(2);
        check_frame1_writes("t7");
        check("t7_done", done, 1);
        check("t7_err", err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
